// File: rtl/log2_rr_sched.sv
// Round-robin scheduler sharing one registered floor-log2 unit among NUM_REQ requesters.
// Tagged responses are held until the consumer accepts them; a single operation is in flight at a time.
module log2_rr_sched #(
  parameter int N       = 8,
  parameter int M       = 3,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_value,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [M-1:0]         rsp_result,
  output logic                 rsp_exact,
  output logic                 rsp_zero,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, next_state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            any_req;
  logic [N-1:0]    op;
  logic [ID_W-1:0] id;
  logic [N-1:0]    vals [NUM_REQ];
  logic [M-1:0]    log_res;
  logic            log_exact;
  logic            log_zero;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign vals[g] = req_value[g*N +: N];
  end

  // Round-robin search starting at rr_ptr; walking down means the closest index wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx     = '0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + ID_W'(k);
      if (req_valid[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

  // Shared floor-log2 unit: highest set bit of the captured operand.
  always_comb begin
    log_res = '0;
    for (int i = 0; i < N; i++) begin
      if (op[i]) log_res = M'(i);
    end
    log_zero  = (op == '0);
    log_exact = !log_zero && ((op & (op - N'(1))) == '0);
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[grant] = 1'b1;
          next_state       = CALC;
        end
      end
      CALC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      op         <= '0;
      id         <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_exact  <= 1'b0;
      rsp_zero   <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op     <= vals[grant];
            id     <= grant;
            rr_ptr <= grant + ID_W'(1);
          end
        end
        CALC: begin
          rsp_id     <= id;
          rsp_result <= log_res;
          rsp_exact  <= log_exact;
          rsp_zero   <= log_zero;
        end
        RESP: begin
          if (rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_log2_rr_sched.sv
// Directed self-checking bench for log2_rr_sched; counter width reduced to 4 bits
// so the done_cnt wrap is reachable in a few dozen operations.
module tb_log2_rr_sched;

  localparam int N = 8, M = 3, NUM_REQ = 4, ID_W = 2, CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*N-1:0] req_value;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [M-1:0]         rsp_result;
  logic                 rsp_exact;
  logic                 rsp_zero;
  logic                 busy;
  logic [CNT_W-1:0]     done_cnt;

  int checks = 0;
  int errors = 0;

  log2_rr_sched #(.N(N), .M(M), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_exact(rsp_exact), .rsp_zero(rsp_zero),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from requester r with rsp_ready high; handshake cycle T, response T+2.
  task automatic do_op(input int r, input logic [7:0] v, input int er, input int ee,
                       input int ez, input int ecnt);
    req_valid = NUM_REQ'(1) << r;
    req_value[r*N +: N] = v;
    rsp_ready = 1'b1;
    #1;
    check("op_req_ready", 32'(req_ready), 32'(NUM_REQ'(1) << r));
    tick();
    req_valid = '0;
    #1;
    check("op_calc_busy", 32'(busy), 1);
    check("op_calc_valid", 32'(rsp_valid), 0);
    check("op_calc_ready", 32'(req_ready), 0);
    tick();
    check("op_rsp_valid", 32'(rsp_valid), 1);
    check("op_rsp_id", 32'(rsp_id), r);
    check("op_rsp_result", 32'(rsp_result), er);
    check("op_rsp_exact", 32'(rsp_exact), ee);
    check("op_rsp_zero", 32'(rsp_zero), ez);
    tick();
    check("op_idle_valid", 32'(rsp_valid), 0);
    check("op_idle_busy", 32'(busy), 0);
    check("op_done_cnt", 32'(done_cnt), ecnt);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_value = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(done_cnt), 0);
    check("rst_fields", {rsp_id, rsp_result, rsp_exact, rsp_zero}, 0);
    check("rst_ready", 32'(req_ready), 0);
    tick();
    rst = 1'b1;
    tick();

    // Single-requester operations; rr_ptr moves 0->1->3->2->0.
    do_op(0, 8'd40, 5, 0, 0, 1);
    do_op(2, 8'd64, 6, 1, 0, 2);
    do_op(1, 8'd0, 0, 0, 1, 3);
    do_op(3, 8'd255, 7, 0, 0, 4);

    // All requesters active: grants rotate 0,1,2,3,0,1 every 3 cycles.
    req_value = {8'd16, 8'd8, 8'd4, 8'd2};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_idle_valid", 32'(rsp_valid), 0);
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      tick();
      check("rr_rsp_valid", 32'(rsp_valid), 1);
      check("rr_rsp_id", 32'(rsp_id), k % 4);
      check("rr_rsp_result", 32'(rsp_result), (k % 4) + 1);
      tick();
    end
    req_valid = '0;
    #1;
    check("rr_done_cnt", 32'(done_cnt), 10);

    // Backpressure: requester 0 (rr_ptr=2, only 0 valid), value 100 -> 6, not exact.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_value[0 +: N] = 8'd100;
    #1;
    check("bp_grant", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = 4'b0010;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_fields", {rsp_id, rsp_result, rsp_exact, rsp_zero}, {2'd0, 3'd6, 1'b0, 1'b0});
      check("bp_busy", 32'(busy), 1);
      check("bp_ready", 32'(req_ready), 0);
      check("bp_cnt", 32'(done_cnt), 10);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_last_valid", 32'(rsp_valid), 1);
    tick();
    check("bp_idle_valid", 32'(rsp_valid), 0);
    check("bp_idle_cnt", 32'(done_cnt), 11);
    check("bp_next_grant", 32'(req_ready), 32'(4'b0010));
    req_valid = '0;
    #1;
    check("bp_drop_ready", 32'(req_ready), 0);
    check("bp_drop_busy", 32'(busy), 0);
    tick();
    check("bp_stay_idle", 32'(busy), 0);

    // Reset during CALC: requester 2 granted (rr_ptr=1), value 16.
    req_valid = 4'b0100;
    req_value[2*N +: N] = 8'd16;
    #1;
    check("rc_grant", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    check("rc_in_calc", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rc_valid", 32'(rsp_valid), 0);
    check("rc_busy", 32'(busy), 0);
    check("rc_cnt", 32'(done_cnt), 0);
    check("rc_fields", {rsp_id, rsp_result, rsp_exact, rsp_zero}, 0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rc_no_rsp", 32'(rsp_valid), 0);
      check("rc_idle", 32'(busy), 0);
    end
    req_valid = 4'b1111;
    #1;
    check("rc_grant0", 32'(req_ready), 32'(4'b0001));
    req_valid = '0;

    // Counter wrap with the 4-bit counter: 1..15, then 0.
    req_value = '0;
    do_op(0, 8'd1, 0, 1, 0, 1);
    for (int k = 2; k <= 15; k++) begin
      do_op(0, 8'd3, 1, 0, 0, k);
    end
    do_op(0, 8'd128, 7, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/log2_rr_sched.md
Name: log2_rr_sched

Overview:
- Round-robin scheduler that shares one registered floor-log2 unit among NUM_REQ requesters.
- Each requester presents an N-bit operand over a valid/ready handshake.
- The scheduler grants one requester, sequences the shared unit, and returns a tagged response: result, exact-power-of-2 flag and zero flag. The response is held until the consumer accepts it.
- Sits between per-channel operand producers and a common result consumer. One operation is in flight at a time.

Parameters:
- N, 8, operand width in bits (N >= 2).
- M, 3, result width; must equal $clog2(N).
- NUM_REQ, 4, number of requesters (power of 2, >= 2).
- ID_W, 2, requester-id width; must equal $clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_value  in  NUM_REQ*N  operands; requester i uses bits [i*N +: N].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  ID_W  index of the requester the response belongs to.
- rsp_result  out  M  floor(log2(value)); 0 when value==0.
- rsp_exact  out  1  1 iff value is a nonzero power of 2.
- rsp_zero  out  1  1 iff value==0.
- busy  out  1  1 whenever state != IDLE.
- done_cnt  out  CNT_W  count of completed response handshakes, wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rr_ptr=0; operand/id registers=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_exact=0, rsp_zero=0, busy=0, done_cnt=0.
  - Reset mid-operation discards the in-flight operation with no response; requesters must re-present.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready is combinational: req_ready[grant]=1 only in IDLE with any req_valid set; all other bits 0.
  - On the handshake edge: capture req_value[grant] and grant into op/id registers; rr_ptr <= grant+1 mod NUM_REQ; go to CALC.
  - With no request, stay in IDLE.
- CALC (exactly 1 cycle):
  - Shared unit registers result = index of the highest set bit of op, exact = (op & (op-1))==0 && op!=0, zero = (op==0).
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/result/exact/zero stable until the handshake.
  - On rsp_valid&&rsp_ready: done_cnt += 1 (wraps 2^CNT_W-1 -> 0); go to IDLE.
  - rsp_valid is deasserted on the following cycle.
  - With no rsp_ready, hold indefinitely.
  - req_ready is all-zero in CALC and RESP.
- Latency: request handshake in cycle T gives rsp_valid=1 in cycle T+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Fairness: a requester holding req_valid is granted within NUM_REQ grants. Requester 0 has top priority after reset.
- Requesters may drop req_valid before the handshake. Grant is re-evaluated every IDLE cycle with no latching.
- A handshake already taken is not cancelled by the requester later dropping req_valid.
- rsp_ready outside RESP is ignored.
- Response fields are don't-care when rsp_valid=0, but hold their last values; they update only on CALC->RESP.

Test Plan:
- Reset, then req_valid=4'b0001, value0=8'd40, rsp_ready=1 -> req_ready=0001 in cycle 0; rsp_valid in cycle 2 with id=0, result=5, exact=0, zero=0; done_cnt=1.
- Requester 2 sends 8'd64 -> result=6, exact=1. Requester 1 sends 8'd0 -> result=0, exact=0, zero=1. Requester 3 sends 8'd255 -> result=7, exact=0.
- All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; responses spaced 3 cycles apart; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and all fields stable; busy=1; req_ready=0000. Then rsp_ready=1 for 1 cycle -> IDLE on the next cycle.
- Reset asserted during CALC with value 8'd16 -> all outputs 0 immediately; no response after release; next grant goes to requester 0 (rr_ptr=0).
- Force done_cnt to 16'hFFFF via 65535 operations (or CNT_W=4 with 15 operations) -> next completion wraps done_cnt to 0.
